// File: rtl/fp_add_seq.sv
// Multi-cycle IEEE-754 single-precision adder/subtractor with valid/ready on both sides.
// One operation in flight; an FSM steps through classify, add, normalize and round.
module fp_add_seq #(
  parameter int unsigned FTZ = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        special,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, CLASS, ALIGN, ADD, NORM, ROUND, DONE} state_t;
  typedef enum logic [2:0] {
    T_ZERO = 3'b000, T_INF = 3'b001, T_SUB = 3'b010, T_NORM = 3'b011, T_NAN = 3'b100
  } ftype_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic        special_q, special_d, sign_q, sign_d, eff_sub_q, eff_sub_d;
  logic [23:0] xsig_q, xsig_d;
  logic [26:0] yext_q, yext_d, m_q, m_d;
  logic [8:0]  exp_q, exp_d;

  ftype_t      ta, tb;
  logic        spec_hit, swap, rnd_inc;
  logic [31:0] spec_res, x, y, rnd_res;
  logic [7:0]  ex, ey, diff;
  logic [4:0]  sh;
  logic [51:0] wide;
  logic [26:0] y_ext;
  logic [27:0] sum;
  logic [24:0] sig25;
  logic [23:0] rsig;
  logic [8:0]  rexp;

  function automatic ftype_t classify(input logic [31:0] v);
    ftype_t t;
    if (v[30:23] == 8'hFF) begin
      if (v[22:0] == '0) t = T_INF;
      else               t = T_NAN;
    end else if (v[30:23] == 8'h00) begin
      if (v[22:0] == '0 || FTZ != 0) t = T_ZERO;
      else                           t = T_SUB;
    end else begin
      t = T_NORM;
    end
    return t;
  endfunction

  always_comb begin
    ta       = classify(a_q);
    tb       = classify(b_q);
    spec_hit = 1'b1;
    spec_res = '0;
    if (ta == T_NAN || tb == T_NAN) begin
      if (ta == T_NAN && (tb != T_NAN || a_q[21:0] >= b_q[21:0])) spec_res = a_q | 32'h0040_0000;
      else                                                        spec_res = b_q | 32'h0040_0000;
    end else if (ta == T_ZERO && tb == T_ZERO) begin
      spec_res = {a_q[31] & b_q[31], 31'd0};
    end else if (ta == T_ZERO) begin
      spec_res = b_q;
    end else if (tb == T_ZERO) begin
      spec_res = a_q;
    end else if (ta == T_INF && tb == T_INF) begin
      spec_res = (a_q[31] == b_q[31]) ? a_q : 32'h7FC0_0000;
    end else if (ta == T_INF) begin
      spec_res = a_q;
    end else if (tb == T_INF) begin
      spec_res = b_q;
    end else begin
      spec_hit = 1'b0;
    end
  end

  // Alignment is computed during CLASS so the normal path needs no separate ALIGN cycle.
  always_comb begin
    swap  = b_q[30:0] > a_q[30:0];
    x     = swap ? b_q : a_q;
    y     = swap ? a_q : b_q;
    ex    = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey    = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    diff  = ex - ey;
    sh    = (diff > 8'd26) ? 5'd26 : diff[4:0];
    wide  = {y[30:23] != 8'd0, y[22:0], 28'd0} >> sh;
    y_ext = {wide[51:26], |wide[25:0]};
  end

  always_comb begin
    if (eff_sub_q) sum = {1'b0, xsig_q, 3'b000} - {1'b0, yext_q};
    else           sum = {1'b0, xsig_q, 3'b000} + {1'b0, yext_q};
  end

  always_comb begin
    rnd_inc = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
    sig25   = {1'b0, m_q[26:3]} + {24'd0, rnd_inc};
    if (sig25[24]) begin
      rsig = sig25[24:1];
      rexp = exp_q + 9'd1;
    end else begin
      rsig = sig25[23:0];
      rexp = exp_q;
    end
    if (rexp >= 9'd255)  rnd_res = {sign_q, 8'hFF, 23'd0};
    else if (!rsig[23])  rnd_res = (FTZ != 0) ? {sign_q, 31'd0} : {sign_q, 8'h00, rsig[22:0]};
    else                 rnd_res = {sign_q, rexp[7:0], rsig[22:0]};
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    special_d = special_q;
    sign_d    = sign_q;
    eff_sub_d = eff_sub_q;
    xsig_d    = xsig_q;
    yext_d    = yext_q;
    m_d       = m_q;
    exp_d     = exp_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = {b[31] ^ sub, b[30:0]};
          state_d = CLASS;
        end
      end
      CLASS: begin
        if (spec_hit) begin
          result_d  = spec_res;
          special_d = 1'b1;
          state_d   = DONE;
        end else begin
          sign_d    = x[31];
          eff_sub_d = x[31] ^ y[31];
          xsig_d    = {x[30:23] != 8'd0, x[22:0]};
          yext_d    = y_ext;
          exp_d     = {1'b0, ex};
          state_d   = ADD;
        end
      end
      ADD: begin
        if (sum == '0) begin
          result_d = '0;
          state_d  = DONE;
        end else if (sum[27]) begin
          m_d     = {sum[27:2], sum[1] | sum[0]};
          exp_d   = exp_q + 9'd1;
          state_d = NORM;
        end else begin
          m_d     = sum[26:0];
          state_d = NORM;
        end
      end
      NORM: begin
        if (!m_q[26] && exp_q > 9'd1) begin
          m_d   = {m_q[25:0], 1'b0};
          exp_d = exp_q - 9'd1;
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        result_d = rnd_res;
        state_d  = DONE;
      end
      DONE: begin
        if (out_ready) begin
          special_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      special_q <= 1'b0;
      sign_q    <= 1'b0;
      eff_sub_q <= 1'b0;
      xsig_q    <= '0;
      yext_q    <= '0;
      m_q       <= '0;
      exp_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      special_q <= special_d;
      sign_q    <= sign_d;
      eff_sub_q <= eff_sub_d;
      xsig_q    <= xsig_d;
      yext_q    <= yext_d;
      m_q       <= m_d;
      exp_q     <= exp_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign special   = special_q;

endmodule
